// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state and scoreboard entry types for the hazard scoreboard
package hazard_pkg;
  localparam int SB_RD_W = 8;
  typedef enum logic {IDLE, WAIT_PC} state_e;
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one source register against every in-flight destination
module hazard_match
  import hazard_pkg::*;
#(
  parameter int STAGES         = 3,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic [SB_RD_W-1:0]     src_i,
  input  logic                   used_i,
  input  sb_entry_t [STAGES-1:0] entries_i,
  output logic                   hit_o
);
  logic [STAGES-1:0] m;
  for (genvar g = 0; g < STAGES; g++) begin : g_cmp
    assign m[g] = entries_i[g].valid && (entries_i[g].rd == src_i);
  end
  assign hit_o = used_i && (|m) && !(ZERO_HARDWIRED && (src_i == '0));
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations for data hazards and stalls on
// control transfers until the PC redirect lands, with a watchdog on the wait.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int STAGES         = 3,
  parameter int DATA_SEG_REG   = 14,
  parameter int MAX_WAIT       = 16,
  parameter bit ZERO_HARDWIRED = 1'b1,
  localparam int REG_W         = $clog2(NUM_REGS),
  localparam int IW            = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             rd_used,
  input  logic             rd_we,
  input  logic             data_reg,
  input  logic             ret,
  input  logic             call,
  input  logic             pc_update,
  input  logic             flush,
  output logic             data_hazard,
  output logic             pc_hazard,
  output logic             stall,
  output logic             timeout_err,
  output logic [IW-1:0]    inflight
);
  localparam int CW = $clog2(MAX_WAIT);

  sb_entry_t [STAGES-1:0] entry_q, entry_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   hit_s, hit_t, hit_d;
  logic [SB_RD_W-1:0]     src_s;

  assign src_s = data_reg ? SB_RD_W'(DATA_SEG_REG) : SB_RD_W'(rs);

  hazard_match #(.STAGES(STAGES), .ZERO_HARDWIRED(ZERO_HARDWIRED)) u_match_s (
    .src_i(src_s), .used_i(rs_used), .entries_i(entry_q), .hit_o(hit_s));
  hazard_match #(.STAGES(STAGES), .ZERO_HARDWIRED(ZERO_HARDWIRED)) u_match_t (
    .src_i(SB_RD_W'(rt)), .used_i(rt_used), .entries_i(entry_q), .hit_o(hit_t));
  hazard_match #(.STAGES(STAGES), .ZERO_HARDWIRED(ZERO_HARDWIRED)) u_match_d (
    .src_i(SB_RD_W'(rd)), .used_i(rd_used), .entries_i(entry_q), .hit_o(hit_d));

  assign data_hazard = issue_valid && (state_q == IDLE) && (hit_s || hit_t || hit_d);
  assign pc_hazard   = (state_q == WAIT_PC) && !pc_update;
  assign stall       = data_hazard || pc_hazard;
  assign timeout_err = err_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) inflight = inflight + IW'(entry_q[i].valid);
  end

  // The pipe keeps draining while stalled; a stalled slot enters as a bubble.
  always_comb begin
    entry_d[0] = (issue_valid && rd_we && !stall) ? {1'b1, SB_RD_W'(rd)} : '0;
    for (int i = 1; i < STAGES; i++) entry_d[i] = entry_q[i-1];
    if (flush) entry_d = '0;
  end

  // Timeout fires on the cycle the counter would reach MAX_WAIT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (issue_valid && (ret || call) && !data_hazard) begin
        state_d = WAIT_PC;
        cnt_d   = '0;
      end
    end else if (pc_update) begin
      state_d = IDLE;
    end else if (cnt_q == CW'(MAX_WAIT - 2)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of data hazards, PC waits, timeout, flush and reset
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid, rs_used, rt_used, rd_used, rd_we, data_reg;
  logic       ret, call, pc_update, flush;
  logic [3:0] rs, rt, rd;
  logic       data_hazard, pc_hazard, stall, timeout_err;
  logic [1:0] inflight;
  int         n_chk = 0;
  int         n_fail = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs(rs), .rt(rt), .rd(rd),
    .rs_used(rs_used), .rt_used(rt_used), .rd_used(rd_used), .rd_we(rd_we),
    .data_reg(data_reg), .ret(ret), .call(call), .pc_update(pc_update), .flush(flush),
    .data_hazard(data_hazard), .pc_hazard(pc_hazard), .stall(stall),
    .timeout_err(timeout_err), .inflight(inflight));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {issue_valid, rs_used, rt_used, rd_used, rd_we, data_reg} = '0;
    {ret, call, pc_update, flush} = '0;
    {rs, rt, rd} = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    issue_valid = 1'b1; rs_used = 1'b1; rs = 4'd5;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_data_hazard", data_hazard, 0);
    chk("rst_pc_hazard", pc_hazard, 0);
    chk("rst_stall", stall, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_timeout", timeout_err, 0);
    idle();
    rst = 1'b0;

    // write r5, then read it back for three cycles
    tick();
    issue_valid = 1'b1; rd_we = 1'b1; rd = 4'd5; settle();
    chk("w5_no_hazard", data_hazard, 0);
    chk("w5_no_stall", stall, 0);
    tick();
    idle(); issue_valid = 1'b1; rs_used = 1'b1; rs = 4'd5; settle();
    chk("r5_c1", data_hazard, 1);
    chk("r5_c1_stall", stall, 1);
    chk("r5_c1_inflight", inflight, 1);
    tick(); settle();
    chk("r5_c2", data_hazard, 1);
    chk("r5_c2_inflight", inflight, 1);
    tick(); settle();
    chk("r5_c3", data_hazard, 1);
    tick(); settle();
    chk("r5_c4", data_hazard, 0);
    chk("r5_c4_inflight", inflight, 0);

    // r0 is never a hazard
    idle(); issue_valid = 1'b1; rd_we = 1'b1; rd = 4'd0;
    tick();
    idle(); issue_valid = 1'b1; rs_used = 1'b1; rs = 4'd0; settle();
    chk("r0_inflight", inflight, 1);
    chk("r0_no_hazard", data_hazard, 0);
    idle(); repeat (3) tick();

    // data segment register substitution
    issue_valid = 1'b1; rd_we = 1'b1; rd = 4'd14;
    tick();
    idle(); issue_valid = 1'b1; rs_used = 1'b1; rs = 4'd3; data_reg = 1'b1; settle();
    chk("dseg_hit", data_hazard, 1);
    data_reg = 1'b0; settle();
    chk("dseg_off", data_hazard, 0);
    rs_used = 1'b0; rt_used = 1'b1; rt = 4'd14; settle();
    chk("rt_hit", data_hazard, 1);
    rt_used = 1'b0; rd_used = 1'b1; rd = 4'd14; settle();
    chk("rd_src_hit", data_hazard, 1);
    rd_used = 1'b0; settle();
    chk("unused_src", data_hazard, 0);
    idle(); repeat (3) tick();

    // call with redirect on cycle 4
    issue_valid = 1'b1; call = 1'b1; settle();
    chk("call_c0_pc", pc_hazard, 0);
    tick(); idle(); settle();
    chk("call_c1_pc", pc_hazard, 1);
    chk("call_c1_stall", stall, 1);
    tick(); settle();
    chk("call_c2_pc", pc_hazard, 1);
    tick(); settle();
    chk("call_c3_pc", pc_hazard, 1);
    tick(); pc_update = 1'b1; settle();
    chk("call_c4_pc", pc_hazard, 0);
    chk("call_c4_stall", stall, 0);
    tick(); idle(); settle();
    chk("call_idle_pc", pc_hazard, 0);
    chk("call_no_err", timeout_err, 0);
    pc_update = 1'b1;
    tick(); idle(); settle();
    chk("pcu_idle_ignored", pc_hazard, 0);

    // ret and call together: one transfer
    issue_valid = 1'b1; ret = 1'b1; call = 1'b1;
    tick(); idle(); settle();
    chk("both_wait", pc_hazard, 1);
    pc_update = 1'b1;
    tick(); idle(); settle();
    chk("both_done", pc_hazard, 0);

    // ret with no redirect: timeout after 15 wait cycles
    issue_valid = 1'b1; ret = 1'b1;
    tick(); idle();
    for (int k = 1; k <= 15; k++) begin
      settle();
      chk($sformatf("to_wait_c%0d", k), pc_hazard, 1);
      chk($sformatf("to_err_c%0d", k), timeout_err, 0);
      tick();
    end
    settle();
    chk("to_pc_released", pc_hazard, 0);
    chk("to_err_set", timeout_err, 1);
    tick(); settle();
    chk("to_err_sticky", timeout_err, 1);

    // reset clears the sticky error
    rst = 1'b1; settle();
    chk("rst_clears_err", timeout_err, 0);
    tick(); rst = 1'b0;

    // redirect in the timeout cycle wins
    issue_valid = 1'b1; ret = 1'b1;
    tick(); idle();
    repeat (14) tick();
    settle();
    chk("win_c15_pc", pc_hazard, 1);
    pc_update = 1'b1; settle();
    chk("win_pc", pc_hazard, 0);
    tick(); idle(); settle();
    chk("win_no_err", timeout_err, 0);
    chk("win_idle", pc_hazard, 0);

    // reset mid-wait abandons without error
    issue_valid = 1'b1; call = 1'b1;
    tick(); idle();
    repeat (4) tick();
    rst = 1'b1; settle();
    chk("midrst_pc", pc_hazard, 0);
    chk("midrst_err", timeout_err, 0);
    tick(); rst = 1'b0;
    repeat (20) tick();
    chk("midrst_late_err", timeout_err, 0);
    chk("midrst_late_pc", pc_hazard, 0);

    // flush with three valid entries
    for (int k = 1; k <= 3; k++) begin
      issue_valid = 1'b1; rd_we = 1'b1; rd = 4'(k);
      tick();
    end
    idle(); settle();
    chk("fl_full", inflight, 3);
    issue_valid = 1'b1; rs_used = 1'b1; rs = 4'd2; settle();
    chk("fl_pre_hazard", data_hazard, 1);
    flush = 1'b1;
    tick(); flush = 1'b0; settle();
    chk("fl_inflight", inflight, 0);
    chk("fl_hazard_clear", data_hazard, 0);

    // flush beats a simultaneous issue
    idle(); issue_valid = 1'b1; rd_we = 1'b1; rd = 4'd7; call = 1'b1; flush = 1'b1;
    tick(); idle(); settle();
    chk("fl_prio_inflight", inflight, 0);
    chk("fl_prio_pc", pc_hazard, 0);

    // flush releases a pending wait
    issue_valid = 1'b1; call = 1'b1;
    tick(); idle(); settle();
    chk("fl_wait_pc", pc_hazard, 1);
    flush = 1'b1;
    tick(); idle(); settle();
    chk("fl_wait_released", pc_hazard, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
